vdp18_pat_fetch: RTL and testbench

Pattern-fetch sequencer that feeds the pattern generation controller. It divides each active line into 2-pixel VRAM access slots, then drives access_type_o, the 14-bit VRAM address and the one-cycle access strobe. The pattern controller consumes these to latch name, colour and generator bytes. CPU accesses are granted only in dedicated slots.

---
 rtl/vdp18_pkg.sv | 25 ++
 rtl/vdp18_pat_fetch_if.sv | 27 ++
 rtl/vdp18_pat_fetch.sv | 193 +++++++++++++++++++
 tb/tb_vdp18_pat_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vdp18_pkg.sv
// Shared types for the VDP18 display pipeline: display modes, VRAM access
// slot types and the pattern-fetch sequencer state.
package vdp18_pkg;

  typedef enum logic [1:0] {
    OPMODE_GRAPH1,
    OPMODE_GRAPH2,
    OPMODE_MULTIC,
    OPMODE_TEXTM
  } opmode_t;

  typedef enum logic [2:0] {
    AC_NONE,
    AC_PNT,
    AC_PCT,
    AC_PGT,
    AC_CPU
  } access_t;

  typedef enum logic {
    ST_IDLE,
    ST_FETCH
  } fetch_state_t;

endpackage

// File: rtl/vdp18_pat_fetch_if.sv
// VRAM access bus of the pattern-fetch sequencer: the CPU request/grant pair
// and the slot type, address and strobe handed to the pattern controller.
interface vdp18_pat_fetch_if;
  import vdp18_pkg::*;

  // cpu_req_i is a level held by the requester; cpu_ack_o is a one-cycle grant
  // coincident with clk_en_acc_o. After the ack the requester must drop
  // cpu_req_i or it is granted again in the next eligible slot.
  logic         cpu_req_i;
  logic [0:13]  cpu_addr_i;
  logic         cpu_ack_o;
  access_t      access_type_o;
  logic         clk_en_acc_o;
  logic [0:13]  vram_a_o;
  fetch_state_t state_dbg_o;

  modport master (
    input  cpu_req_i, cpu_addr_i,
    output cpu_ack_o, access_type_o, clk_en_acc_o, vram_a_o, state_dbg_o
  );

  modport slave (
    output cpu_req_i, cpu_addr_i,
    input  cpu_ack_o, access_type_o, clk_en_acc_o, vram_a_o, state_dbg_o
  );

endinterface

// File: rtl/vdp18_pat_fetch.sv
// Pattern-fetch sequencer: splits each line into 2-pixel VRAM slots and issues
// name/colour/generator/CPU accesses. Define VDP18_CPU_BLANK_EN to open every
// blanking slot to the CPU instead of every 4th.
module vdp18_pat_fetch
  import vdp18_pkg::*;
#(
  parameter int GFX_START = -8,
  parameter int TXT_START = -6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_5m37_i,
  input  opmode_t           opmode_i,
  input  logic signed [0:8] num_pix_i,
  input  logic signed [0:8] num_line_i,
  input  logic [0:9]        pat_table_i,
  input  logic [0:7]        pat_name_i,
  input  logic [0:3]        reg_ntb_i,
  input  logic [0:2]        reg_ptb_i,
  input  logic [0:7]        reg_ctb_i,
  vdp18_pat_fetch_if.master bus
);

  localparam logic signed [0:8] GFX_START_C = 9'(GFX_START);
  localparam logic signed [0:8] TXT_START_C = 9'(TXT_START);

  fetch_state_t state_q, state_d;
  logic         phase_q, phase_d;   // 0: next enable starts a slot, 1: ends it
  logic [1:0]   slot_q, slot_d;
  logic [5:0]   cell_q, cell_d;
  logic [1:0]   idle_q, idle_d;
  opmode_t      mode_q, mode_d;
  access_t      type_q, type_d;
  logic [0:13]  addr_q, addr_d;
  logic         strobe_q, strobe_d;
  logic         grant_q, grant_d;

  logic              open_w, start_w, end_w, in_fetch_w, idle_cpu_w;
  logic              last_slot_w, last_cell_w;
  logic signed [0:8] start_pix_w;
  opmode_t           eff_mode_w;
  logic [1:0]        eff_slot_w;
  access_t           kind_w;

  function automatic access_t fetch_kind(input opmode_t m, input logic [1:0] s);
    access_t k;
    if (m == OPMODE_TEXTM) begin
      case (s)
        2'd0:    k = AC_PNT;
        2'd1:    k = AC_PGT;
        default: k = AC_CPU;
      endcase
    end else begin
      case (s)
        2'd0:    k = AC_PNT;
        2'd1:    k = (m == OPMODE_MULTIC) ? AC_NONE : AC_PCT;
        2'd2:    k = AC_PGT;
        default: k = AC_CPU;
      endcase
    end
    return k;
  endfunction

`ifdef VDP18_CPU_BLANK_EN
  assign idle_cpu_w = 1'b1;
`else
  assign idle_cpu_w = (idle_q == 2'd3);
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    slot_d   = slot_q;
    cell_d   = cell_q;
    idle_d   = idle_q;
    mode_d   = mode_q;
    type_d   = type_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    grant_d  = grant_q;

    start_pix_w = (opmode_i == OPMODE_TEXTM) ? TXT_START_C : GFX_START_C;
    open_w = clk_en_5m37_i && (state_q == ST_IDLE) && !num_line_i[0] &&
             ($unsigned(num_line_i) < 9'd192) && (num_pix_i == start_pix_w);
    // Window open always begins a fresh slot, aborting any half-done idle slot.
    start_w = clk_en_5m37_i && (open_w || !phase_q);
    end_w   = clk_en_5m37_i && phase_q && !open_w;

    in_fetch_w  = open_w || (state_q == ST_FETCH);
    eff_mode_w  = open_w ? opmode_i : mode_q;
    eff_slot_w  = open_w ? 2'd0 : slot_q;
    kind_w      = in_fetch_w ? fetch_kind(eff_mode_w, eff_slot_w)
                             : (idle_cpu_w ? AC_CPU : AC_NONE);
    last_slot_w = (mode_q == OPMODE_TEXTM) ? (slot_q == 2'd2) : (slot_q == 2'd3);
    last_cell_w = (mode_q == OPMODE_TEXTM) ? (cell_q == 6'd39) : (cell_q == 6'd31);

    if (open_w) begin
      state_d = ST_FETCH;
      mode_d  = opmode_i;
      slot_d  = 2'd0;
      cell_d  = 6'd0;
    end

    if (start_w) begin
      phase_d  = 1'b1;
      grant_d  = 1'b0;
      strobe_d = in_fetch_w;
      type_d   = AC_NONE;
      case (kind_w)
        AC_PNT: begin
          type_d = AC_PNT;
          addr_d = {reg_ntb_i, pat_table_i};
        end
        AC_PCT: begin
          type_d = AC_PCT;
          if (eff_mode_w == OPMODE_GRAPH2)
            addr_d = {reg_ctb_i[0], num_line_i[1:2], pat_name_i, num_line_i[6:8]};
          else
            addr_d = {reg_ctb_i, 1'b0, pat_name_i[0:4]};
        end
        AC_PGT: begin
          type_d = AC_PGT;
          case (eff_mode_w)
            OPMODE_GRAPH2: addr_d = {reg_ptb_i[0], num_line_i[1:2], pat_name_i, num_line_i[6:8]};
            OPMODE_MULTIC: addr_d = {reg_ptb_i, pat_name_i, num_line_i[4:6]};
            default:       addr_d = {reg_ptb_i, pat_name_i, num_line_i[6:8]};
          endcase
        end
        AC_CPU: begin
          if (bus.cpu_req_i) begin
            type_d   = AC_CPU;
            addr_d   = bus.cpu_addr_i;
            grant_d  = 1'b1;
            strobe_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (end_w) begin
      phase_d = 1'b0;
      if (state_q == ST_FETCH) begin
        if (last_slot_w) begin
          slot_d = 2'd0;
          if (last_cell_w) begin
            state_d = ST_IDLE;
            idle_d  = 2'd0;
          end else begin
            cell_d = cell_q + 6'd1;
          end
        end else begin
          slot_d = slot_q + 2'd1;
        end
      end else begin
        idle_d = idle_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      phase_q  <= 1'b0;
      slot_q   <= 2'd0;
      cell_q   <= 6'd0;
      idle_q   <= 2'd0;
      mode_q   <= OPMODE_GRAPH1;
      type_q   <= AC_NONE;
      addr_q   <= '0;
      strobe_q <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      slot_q   <= slot_d;
      cell_q   <= cell_d;
      idle_q   <= idle_d;
      mode_q   <= mode_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      grant_q  <= grant_d;
    end
  end

  assign bus.access_type_o = type_q;
  assign bus.vram_a_o      = addr_q;
  assign bus.clk_en_acc_o  = end_w && strobe_q;
  assign bus.cpu_ack_o     = end_w && grant_q;
  assign bus.state_dbg_o   = state_q;

endmodule

// File: tb/tb_vdp18_pat_fetch.sv
// Directed bench for vdp18_pat_fetch: window timing, slot sequences, address
// formation per mode, CPU slot grants and asynchronous reset.
module tb_vdp18_pat_fetch;
  import vdp18_pkg::*;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              clk_en = 1'b0;
  opmode_t           opmode = OPMODE_GRAPH1;
  logic signed [0:8] num_pix = 9'sd100;
  logic signed [0:8] num_line = 9'sd0;
  logic [0:9]        pat_table = '0;
  logic [0:7]        pat_name = '0;
  logic [0:3]        reg_ntb = '0;
  logic [0:2]        reg_ptb = '0;
  logic [0:7]        reg_ctb = '0;
  logic              cpu_req = 1'b0;
  logic [0:13]       cpu_addr = '0;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int ack_cnt = 0;
  int stray_ack = 0;
  logic        s_acc, s_ack;
  access_t     s_type;
  logic [13:0] s_addr;

  vdp18_pat_fetch_if bus();
  assign bus.cpu_req_i  = cpu_req;
  assign bus.cpu_addr_i = cpu_addr;

  vdp18_pat_fetch dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clk_en_5m37_i (clk_en),
    .opmode_i      (opmode),
    .num_pix_i     (num_pix),
    .num_line_i    (num_line),
    .pat_table_i   (pat_table),
    .pat_name_i    (pat_name),
    .reg_ntb_i     (reg_ntb),
    .reg_ptb_i     (reg_ptb),
    .reg_ctb_i     (reg_ctb),
    .bus           (bus.master)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One pixel enable; strobe/ack sampled while the enable is high, slot
  // type/address sampled just after the clock edge that consumed it.
  task automatic en_pulse();
    @(negedge clk_i);
    clk_en = 1'b1;
    #1;
    s_acc = bus.clk_en_acc_o;
    s_ack = bus.cpu_ack_o;
    if (s_acc) strobe_cnt++;
    if (s_ack) ack_cnt++;
    if (s_ack && bus.access_type_o != AC_CPU) stray_ack++;
    @(posedge clk_i);
    #1;
    s_type = bus.access_type_o;
    s_addr = bus.vram_a_o;
    clk_en = 1'b0;
    @(posedge clk_i);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_type", bus.access_type_o, AC_NONE);
    chk("rst_addr", bus.vram_a_o, 14'h0);
    chk("rst_acc", bus.clk_en_acc_o, 1'b0);
    chk("rst_ack", bus.cpu_ack_o, 1'b0);
    chk("rst_state", bus.state_dbg_o, ST_IDLE);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // Graphics I, line 5
    opmode = OPMODE_GRAPH1; num_line = 9'sd5; reg_ntb = 4'h1; pat_table = 10'h040;
    pat_name = 8'h41; reg_ptb = 3'h2; reg_ctb = 8'h12;
    num_pix = -9'sd8; strobe_cnt = 0; ack_cnt = 0;
    en_pulse();
    chk("g1_pnt_type", s_type, AC_PNT);
    chk("g1_pnt_addr", s_addr, 14'h0440);
    chk("g1_start_no_acc", s_acc, 1'b0);
    num_pix = 9'sd100;
    en_pulse();
    chk("g1_end_acc", s_acc, 1'b1);
    chk("g1_pnt_hold", s_type, AC_PNT);
    en_pulse();
    chk("g1_pct_type", s_type, AC_PCT);
    chk("g1_pct_addr", s_addr, 14'h0488);
    en_pulse();
    en_pulse();
    chk("g1_pgt_type", s_type, AC_PGT);
    chk("g1_pgt_addr", s_addr, 14'h120D);
    en_pulse();
    en_pulse();
    chk("g1_cpu_idle_type", s_type, AC_NONE);
    chk("g1_cpu_idle_addr", s_addr, 14'h120D);
    repeat (248) en_pulse();
    chk("g1_open_at_255", bus.state_dbg_o, ST_FETCH);
    en_pulse();
    chk("g1_closed", bus.state_dbg_o, ST_IDLE);
    chk("g1_strobes", strobe_cnt, 128);
    chk("g1_acks", ack_cnt, 0);
    repeat (8) en_pulse();
    chk("g1_idle_no_strobe", strobe_cnt, 128);
    chk("g1_idle_type", s_type, AC_NONE);

    // Text, line 10: -8 must not open the window
    opmode = OPMODE_TEXTM; num_line = 9'sd10;
    num_pix = -9'sd8;
    en_pulse();
    chk("txt_no_open_gfx_pix", bus.state_dbg_o, ST_IDLE);
    num_pix = -9'sd6; strobe_cnt = 0;
    en_pulse();
    chk("txt_pnt_type", s_type, AC_PNT);
    num_pix = 9'sd100;
    en_pulse();
    en_pulse();
    chk("txt_pgt_type", s_type, AC_PGT);
    chk("txt_pgt_addr", s_addr, 14'h120A);
    en_pulse();
    en_pulse();
    chk("txt_cpu_type", s_type, AC_NONE);
    repeat (234) en_pulse();
    chk("txt_open_at_239", bus.state_dbg_o, ST_FETCH);
    en_pulse();
    chk("txt_closed", bus.state_dbg_o, ST_IDLE);
    chk("txt_strobes", strobe_cnt, 120);

    // Multicolor, line 5: slot 1 is empty and holds the PNT address
    opmode = OPMODE_MULTIC; num_line = 9'sd5; pat_name = 8'h41; reg_ptb = 3'h2;
    num_pix = -9'sd8; strobe_cnt = 0;
    en_pulse();
    num_pix = 9'sd100;
    en_pulse();
    en_pulse();
    chk("mc_none_type", s_type, AC_NONE);
    chk("mc_none_addr", s_addr, 14'h0440);
    en_pulse();
    en_pulse();
    chk("mc_pgt_addr", s_addr, 14'h1209);
    repeat (251) en_pulse();
    chk("mc_strobes", strobe_cnt, 128);

    // Graphics II, line 130 (third screen third) with CPU request held
    opmode = OPMODE_GRAPH2; num_line = 9'sd130; pat_name = 8'h12;
    reg_ctb = 8'hFF; reg_ptb = 3'h4; cpu_addr = 14'h3ABC;
    num_pix = -9'sd8; strobe_cnt = 0; ack_cnt = 0; stray_ack = 0;
    en_pulse();
    chk("g2_pnt_addr", s_addr, 14'h0440);
    num_pix = 9'sd100; cpu_req = 1'b1;
    en_pulse();
    chk("g2_no_ack_pnt", s_ack, 1'b0);
    en_pulse();
    chk("g2_pct_type", s_type, AC_PCT);
    chk("g2_pct_addr", s_addr, 14'h3092);
    en_pulse();
    chk("g2_no_ack_pct", s_ack, 1'b0);
    en_pulse();
    chk("g2_pgt_type", s_type, AC_PGT);
    chk("g2_pgt_addr", s_addr, 14'h3092);
    en_pulse();
    chk("g2_no_ack_pgt", s_ack, 1'b0);
    en_pulse();
    chk("g2_cpu_type", s_type, AC_CPU);
    chk("g2_cpu_addr", s_addr, 14'h3ABC);
    en_pulse();
    chk("g2_cpu_ack", s_ack, 1'b1);
    chk("g2_cpu_acc", s_acc, 1'b1);
    repeat (248) en_pulse();
    chk("g2_closed", bus.state_dbg_o, ST_IDLE);
    chk("g2_acks_per_cell", ack_cnt, 32);
    chk("g2_strobes", strobe_cnt, 128);
    chk("g2_stray_acks", stray_ack, 0);

    // Blanking: 16 idle slots with the request held
    ack_cnt = 0;
    repeat (32) en_pulse();
`ifdef VDP18_CPU_BLANK_EN
    chk("idle_acks", ack_cnt, 16);
`else
    chk("idle_acks", ack_cnt, 4);
`endif
    chk("idle_stray_acks", stray_ack, 0);
    cpu_req = 1'b0;

    // Asynchronous reset in the middle of a PGT slot
    opmode = OPMODE_GRAPH1; num_line = 9'sd5; pat_name = 8'h41; reg_ptb = 3'h2;
    num_pix = -9'sd8;
    en_pulse();
    num_pix = 9'sd100;
    repeat (4) en_pulse();
    chk("rst_mid_pgt_type", s_type, AC_PGT);
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_mid_type", bus.access_type_o, AC_NONE);
    chk("rst_mid_addr", bus.vram_a_o, 14'h0);
    chk("rst_mid_acc", bus.clk_en_acc_o, 1'b0);
    chk("rst_mid_ack", bus.cpu_ack_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
    strobe_cnt = 0;
    repeat (40) en_pulse();
    chk("rst_no_strobe", strobe_cnt, 0);
    chk("rst_state_idle", bus.state_dbg_o, ST_IDLE);
    num_pix = -9'sd8;
    en_pulse();
    chk("rst_reopen_pnt", s_type, AC_PNT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
